// File: rtl/fetch_unit.sv
// Instruction fetch front-end for the single-cycle core.
// Owns the fetch PC, issues word requests to instruction memory, buffers returned
// instructions with their PC in a small FIFO and presents them to decode.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    instruction-memory request channel (registered outputs)
//   rsp_valid/rsp_data/rsp_error    in-order, non-stallable response channel
//   instr_valid/instr_ready         head-of-FIFO handshake toward the core
//   instr_data/instr_pc/instr_fault head entry (NOP data on fault)
//   redirect_valid/redirect_pc      single-cycle fetch restart (branch/jump)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_error,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = PW + 2;
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);

    typedef enum logic {StRun, StHalt} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          req_valid_q, req_valid_d;
    // Held request was overtaken by a redirect; its response must be discarded.
    logic          req_stale_q, req_stale_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] stale_q, stale_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] mem_data_q  [DEPTH];
    logic [31:0] mem_pc_q    [DEPTH];
    logic        mem_fault_q [DEPTH];

    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [31:0]   wr_pc;
    logic          wr_fault;

    logic handshake, misaligned, drop, push, pop, can_issue;

    always_comb begin
        handshake  = req_valid_q & req_ready;
        misaligned = redirect_pc[1:0] != 2'b00;
        drop       = stale_q != '0;
        push       = rsp_valid & ~drop & ~redirect_valid;
        pop        = (count_q != '0) & instr_ready & ~redirect_valid;
        // Credit check: every outstanding request has a FIFO slot reserved.
        can_issue  = (state_q == StRun) & ~req_valid_q & ~redirect_valid &
                     ((inflight_q + IW'(count_q)) < DEPTH_W);

        inflight_d = inflight_q + IW'(handshake) - IW'(rsp_valid);
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        stale_d    = stale_q;

        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_stale_d = req_stale_q;
        if (handshake) begin
            req_valid_d = 1'b0;
            req_stale_d = 1'b0;
        end else if (can_issue) begin
            req_valid_d = 1'b1;
            req_addr_d  = fetch_pc_q;
        end

        wr_en    = 1'b0;
        wr_idx   = wr_ptr_q;
        wr_data  = rsp_error ? NOP : rsp_data;
        wr_pc    = rsp_pc_q;
        wr_fault = rsp_error;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            // Everything still owed by memory, including a request accepted now, is stale.
            stale_d    = inflight_d;
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            state_d    = misaligned ? StHalt : StRun;
            if (req_valid_q & ~req_ready) begin
                req_stale_d = 1'b1;
            end
            rd_ptr_d = '0;
            if (misaligned) begin
                wr_en    = 1'b1;
                wr_idx   = '0;
                wr_data  = NOP;
                wr_pc    = redirect_pc;
                wr_fault = 1'b1;
                wr_ptr_d = PW'(1);
                count_d  = CW'(1);
            end else begin
                wr_ptr_d = '0;
                count_d  = '0;
            end
        end else begin
            // A held stale request joins the stale count when it is finally accepted.
            stale_d = stale_q + IW'(handshake & req_stale_q) - IW'(rsp_valid & drop);
            if (handshake & ~req_stale_q) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
                if (rsp_error) begin
                    state_d = StHalt;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            req_addr_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_stale_q <= 1'b0;
            inflight_q  <= '0;
            stale_q     <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i]  <= '0;
                mem_pc_q[i]    <= '0;
                mem_fault_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            req_stale_q <= req_stale_d;
            inflight_q  <= inflight_d;
            stale_q     <= stale_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            if (wr_en) begin
                mem_data_q[wr_idx]  <= wr_data;
                mem_pc_q[wr_idx]    <= wr_pc;
                mem_fault_q[wr_idx] <= wr_fault;
            end
        end
    end

    assign req_valid   = req_valid_q;
    assign req_addr    = req_addr_q;
    assign instr_valid = count_q != '0;
    assign instr_data  = mem_data_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];
    assign instr_fault = mem_fault_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with configurable latency,
// scoreboard of expected core-side entries, and a table of redirect scenarios.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_data;
    logic        instr_valid, instr_ready, instr_fault;
    logic [31:0] instr_data, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; logic fault; } exp_t;
    typedef struct { logic [31:0] addr; logic stale; int due; } mreq_t;
    typedef struct {
        int          lat;
        bit          hold;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
        logic        exp_fault;
        bit          exp_halt;
    } vec_t;

    exp_t  sb_q[$];
    mreq_t pend_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int mem_lat = 1;
    int hs_total = 0;
    int max_live = 0;
    int pops, post_reqs, post_rv;
    logic        mem_rdy, core_rdy, do_redir, held_stale;
    logic [31:0] redir_target, exp_fetch, err_addr;
    logic        first_seen, first_fault, fault_seen;
    logic [31:0] first_pc, first_data, post_req1, fault_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        pops       = 0;
        post_reqs  = 0;
        post_rv    = 0;
        post_req1  = 32'hDEAD_BEEF;
        first_seen = 1'b0;
        first_pc   = 32'hDEAD_BEEF;
        first_data = 32'hDEAD_BEEF;
        first_fault = 1'bx;
        fault_seen = 1'b0;
        fault_pc   = 32'hDEAD_BEEF;
    endtask

    task automatic pop_one();
        exp_t e;
        if (!first_seen) begin
            first_seen  = 1'b1;
            first_pc    = instr_pc;
            first_data  = instr_data;
            first_fault = instr_fault;
        end
        if (instr_fault) begin
            fault_seen = 1'b1;
            fault_pc   = instr_pc;
        end
        pops++;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_entry: got pc %08h data %08h, want no entry",
                     instr_pc, instr_data);
        end else begin
            e = sb_q.pop_front();
            check("entry_pc", instr_pc, e.pc);
            check("entry_data", instr_data, e.data);
            check("entry_fault", 32'(instr_fault), 32'(e.fault));
        end
    endtask

    // One clock cycle; called at the falling edge, returns at the next falling edge.
    task automatic tick();
        mreq_t r;
        exp_t  e;
        logic  stale_acc;
        int    live;
        instr_ready    = core_rdy;
        redirect_valid = do_redir;
        redirect_pc    = redir_target;
        if (do_redir) begin
            sb_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            if (req_valid && !mem_rdy) held_stale = 1'b1;
            exp_fetch = redir_target;
            if (redir_target[1:0] != 2'b00) begin
                e.pc = redir_target; e.data = NOP; e.fault = 1'b1;
                sb_q.push_back(e);
            end
        end else if (instr_valid && core_rdy) begin
            pop_one();
        end

        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        rsp_error = 1'b0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            r = pend_q.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = r.addr;
            rsp_error = (r.addr == err_addr);
            if (!r.stale) begin
                e.pc = r.addr; e.data = rsp_error ? NOP : r.addr; e.fault = rsp_error;
                sb_q.push_back(e);
            end
        end

        req_ready = mem_rdy;
        if (req_valid) post_rv++;
        if (req_valid && mem_rdy) begin
            stale_acc  = held_stale | do_redir;
            held_stale = 1'b0;
            if (!stale_acc) begin
                check("req_addr", req_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                post_reqs++;
                if (post_reqs == 2) post_req1 = req_addr;
            end
            hs_total++;
            r.addr = req_addr; r.stale = stale_acc; r.due = cyc + mem_lat;
            pend_q.push_back(r);
        end

        live = sb_q.size();
        foreach (pend_q[i]) if (!pend_q[i].stale) live++;
        if (live > max_live) max_live = live;

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = 32'h0;
        rsp_error      = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        pend_q.delete();
        sb_q.delete();
        held_stale   = 1'b0;
        do_redir     = 1'b0;
        redir_target = 32'h0;
        exp_fetch    = RESET_PC;
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", req_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_fault", 32'(instr_fault), 32'd0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        rst_n    = 1'b1;
        mem_lat  = 1;
        mem_rdy  = 1'b1;
        core_rdy = 1'b1;
        err_addr = 32'hFFFF_FFFF;
        hs_total = 0;
        clear_stats();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        int   guard;
        int   hs_snap;
        vecs[0] = '{4, 1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 1'b0, 1'b0};
        vecs[2] = '{1, 1'b0, 32'h0000_0102, 32'h0000_0102, NOP,           1'b1, 1'b1};
        vecs[3] = '{1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0};

        // Free-run from reset.
        do_reset();
        repeat (20) tick();
        check("freerun_pops_ge3", 32'(pops >= 3), 32'd1);
        check("freerun_first_pc", first_pc, RESET_PC);
        check("freerun_first_fault", 32'(first_fault), 32'd0);

        // Asynchronous reset in the middle of traffic takes effect immediately.
        rst_n = 1'b0;
        #1;
        check("midrst_req_valid", 32'(req_valid), 32'd0);
        check("midrst_instr_valid", 32'(instr_valid), 32'd0);
        check("midrst_req_addr", req_addr, RESET_PC);
        @(negedge clk);

        // Core backpressure: only DEPTH requests may be issued.
        do_reset();
        core_rdy = 1'b0;
        repeat (10) tick();
        check("bp_requests", 32'(hs_total), 32'(DEPTH));
        check("bp_fifo_full", 32'(sb_q.size()), 32'(DEPTH));
        check("bp_instr_valid", 32'(instr_valid), 32'd1);
        check("bp_req_valid", 32'(req_valid), 32'd0);
        core_rdy = 1'b1;
        repeat (12) tick();
        check("bp_drained", 32'(pops >= DEPTH), 32'd1);
        check("bp_first_pc", first_pc, RESET_PC);

        // Redirect scenarios.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            mem_lat = vecs[i].lat;
            guard = 0;
            if (vecs[i].hold) begin
                mem_rdy = 1'b0;
                while (!req_valid && guard < 40) begin tick(); guard++; end
                check("vec_setup_held", 32'(guard < 40), 32'd1);
            end else if (vecs[i].lat > 1) begin
                while (!(pend_q.size() == 2 && pend_q[0].due <= cyc) && guard < 40) begin
                    tick();
                    guard++;
                end
                check("vec_setup_two_inflight", 32'(guard < 40), 32'd1);
            end else begin
                repeat (6) tick();
            end
            do_redir = 1'b1;
            redir_target = vecs[i].target;
            tick();
            do_redir = 1'b0;
            clear_stats();
            if (vecs[i].hold) begin
                repeat (3) begin
                    check("held_req_valid", 32'(req_valid), 32'd1);
                    check("held_req_addr", req_addr, RESET_PC);
                    tick();
                end
                mem_rdy = 1'b1;
            end
            repeat (25) tick();
            check("vec_first_seen", 32'(first_seen), 32'd1);
            check("vec_first_pc", first_pc, vecs[i].exp_pc);
            check("vec_first_data", first_data, vecs[i].exp_data);
            check("vec_first_fault", 32'(first_fault), 32'(vecs[i].exp_fault));
            if (vecs[i].exp_halt) begin
                check("vec_halt_no_req_valid", 32'(post_rv), 32'd0);
                check("vec_halt_single_entry", 32'(pops), 32'd1);
            end else begin
                check("vec_req_count", 32'(post_reqs >= 2), 32'd1);
                check("vec_second_req", post_req1, vecs[i].target + 32'd4);
            end
        end

        // Bus error on 0x8 halts fetch; a redirect restarts it.
        do_reset();
        err_addr = 32'h0000_0008;
        repeat (30) tick();
        check("err_fault_seen", 32'(fault_seen), 32'd1);
        check("err_fault_pc", fault_pc, 32'h0000_0008);
        hs_snap = hs_total;
        repeat (10) tick();
        check("err_no_new_requests", 32'(hs_total), 32'(hs_snap));
        check("err_req_valid", 32'(req_valid), 32'd0);
        err_addr = 32'hFFFF_FFFF;
        do_redir = 1'b1;
        redir_target = 32'h0000_0020;
        tick();
        do_redir = 1'b0;
        clear_stats();
        repeat (15) tick();
        check("err_resume_pc", first_pc, 32'h0000_0020);
        check("err_resume_fault", 32'(first_fault), 32'd0);

        check("max_live_le_depth", 32'(max_live <= DEPTH), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
